// File: rtl/ram_io_responder.sv
`timescale 1ns/1ps
// Byte RAM plus MMIO window (TX FIFO, RX holding byte, sim-end flag); reads return the cycle after the address.
// Never stalls the bus; TX writes to a full FIFO are dropped (sticky tx_overflow). RX path: define RAM_IO_RX_EN.
module ram_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 16,
  parameter int TX_PTR_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready,
  output logic        tx_overflow,
  output logic        sim_end
);

  localparam logic [17:0] IO_DATA = 18'h30000;
  localparam logic [17:0] IO_STAT = 18'h30004;
  localparam logic [TX_PTR_W:0] TX_FULL_CNT = (TX_PTR_W+1)'(TX_DEPTH);

  logic [7:0]            ram [0:(2**ADDR_WIDTH)-1];
  logic [7:0]            tx_mem [0:TX_DEPTH-1];
  logic [TX_PTR_W-1:0]   tx_wr_ptr;
  logic [TX_PTR_W-1:0]   tx_rd_ptr;
  logic [TX_PTR_W:0]     tx_count;
  logic [ADDR_WIDTH-1:0] ram_idx;

  logic io_sel;
  logic ram_wr;
  logic ram_rd;
  logic rd_data;
  logic rd_stat;
  logic wr_data;
  logic wr_stat;
  logic tx_full;
  logic tx_pop;
  logic tx_push;
  logic prev_rd_data;
  logic rx_first;
  logic rx_full;
  logic [7:0] rx_byte;
  logic unused_hi;

  assign unused_hi = ^mem_a[31:18];

  assign io_sel  = (mem_a[17:16] == 2'b11);
  assign ram_idx = mem_a[ADDR_WIDTH-1:0];
  assign ram_wr  = mem_wr && !io_sel;
  assign ram_rd  = !mem_wr && !io_sel;
  assign rd_data = !mem_wr && io_sel && (mem_a[17:0] == IO_DATA);
  assign rd_stat = !mem_wr && io_sel && (mem_a[17:0] == IO_STAT);
  assign wr_data = mem_wr && io_sel && (mem_a[17:0] == IO_DATA);
  assign wr_stat = mem_wr && io_sel && (mem_a[17:0] == IO_STAT);

  // Only the first cycle of a run of data-port reads consumes the RX byte.
  assign rx_first = rd_data && !prev_rd_data;

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din      <= 8'h00;
      prev_rd_data <= 1'b0;
    end else begin
      prev_rd_data <= rd_data;
      if (ram_rd) begin
        mem_din <= ram[ram_idx];
      end else if (rd_data) begin
        if (rx_first) begin
          mem_din <= rx_full ? rx_byte : 8'h00;
        end
      end else if (rd_stat) begin
        mem_din <= {6'b0, rx_full, tx_full};
      end else if (!mem_wr) begin
        mem_din <= 8'h00;
      end
    end
  end

  // TX FIFO: a push into a full FIFO is still accepted when the sink pops in the same cycle.
  assign io_tx_valid = (tx_count != '0);
  assign io_tx_data  = tx_mem[tx_rd_ptr];
  assign tx_full     = (tx_count == TX_FULL_CNT);
  assign tx_pop      = io_tx_valid && io_tx_ready;
  assign tx_push     = wr_data && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr] <= mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
      sim_end     <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      if (wr_data && tx_full && !tx_pop) begin
        tx_overflow <= 1'b1;
      end
      if (wr_stat) begin
        sim_end <= 1'b1;
      end
    end
  end

`ifdef RAM_IO_RX_EN
  assign io_rx_ready = !rx_full;

  // Load only when empty and pop only when full, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (io_rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_byte <= io_rx_data;
    end else if (rx_first && rx_full) begin
      rx_full <= 1'b0;
    end
  end
`else
  logic unused_rx;

  assign io_rx_ready = 1'b0;
  assign rx_full     = 1'b0;
  assign rx_byte     = 8'h00;
  assign unused_rx   = ^{io_rx_data, io_rx_valid};
`endif

endmodule

// File: tb/tb_ram_io_responder.sv
`timescale 1ns/1ps
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_a = 32'h0003000C;
  logic        mem_wr = 1'b1;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready = 1'b0;
  logic [7:0]  io_rx_data = 8'h00;
  logic        io_rx_valid = 1'b0;
  logic        io_rx_ready;
  logic        tx_overflow;
  logic        sim_end;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic       cur_rd = 1'b0;
  logic       rd_issued;

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr),
    .mem_dout    (mem_dout),
    .mem_din     (mem_din),
    .io_tx_data  (io_tx_data),
    .io_tx_valid (io_tx_valid),
    .io_tx_ready (io_tx_ready),
    .io_rx_data  (io_rx_data),
    .io_rx_valid (io_rx_valid),
    .io_rx_ready (io_rx_ready),
    .tx_overflow (tx_overflow),
    .sim_end     (sim_end)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read data appears one edge after the address; the scoreboard entry is consumed then.
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_issued <= 1'b0;
    else      rd_issued <= cur_rd;
  end

  always @(negedge clk) begin
    if (rd_issued && rst) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 1);
      end else begin
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, mem_din, e);
      end
    end
  end

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d,
                     input logic rd_chk, input logic [7:0] exp, input string tag);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
    cur_rd   = rd_chk;
    if (rd_chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 1'b0, 8'h00, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    bus(1'b0, a, 8'h00, 1'b1, exp, tag);
  endtask

  task automatic idle();
    bus(1'b1, 32'h0003000C, 8'h00, 1'b0, 8'h00, "");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_valid", io_tx_valid, 1'b0);
    check("rst_overflow", tx_overflow, 1'b0);
    check("rst_sim_end", sim_end, 1'b0);
`ifdef RAM_IO_RX_EN
    check("rst_rx_ready", io_rx_ready, 1'b1);
`else
    check("rst_rx_ready", io_rx_ready, 1'b0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // RAM traffic, including address bits above 17 that must be ignored
    wr(32'h00000010, 8'hA5);
    rd(32'h00000010, 8'hA5, "ram_rd_a5");
    wr(32'h00000011, 8'h99);
    check("ram_wr_hold", mem_din, 8'hA5);
    wr(32'h0001FFFF, 8'h3C);
    wr(32'h00000000, 8'h81);
    rd(32'h0001FFFF, 8'h3C, "ram_rd_top");
    rd(32'h00000000, 8'h81, "ram_rd_zero");
    rd(32'hFFFC0010, 8'hA5, "ram_rd_alias");
    rd(32'h00000011, 8'h99, "ram_rd_99");
    rd(32'h00030008, 8'h00, "io_rd_other");

    // reset while bytes are queued clears TX state without a clock edge
    for (int i = 1; i <= 3; i++) wr(32'h00030000, 8'(i));
    idle();
    check("tx_valid_q3", io_tx_valid, 1'b1);
    check("tx_head_q3", io_tx_data, 8'h01);
    rst = 1'b0;
    #1;
    check("async_rst_tx_valid", io_tx_valid, 1'b0);
    check("async_rst_overflow", tx_overflow, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 17 writes into a 16-deep FIFO with a stalled sink
    for (int i = 1; i <= 17; i++) wr(32'h00030000, 8'(i));
    idle();
    check("ovf_set", tx_overflow, 1'b1);
    rd(32'h00030004, 8'h01, "stat_tx_full");
    io_tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("drain_valid", io_tx_valid, 1'b1);
      check("drain_data", io_tx_data, 8'(i));
      idle();
    end
    io_tx_ready = 1'b0;
    check("drain_empty", io_tx_valid, 1'b0);
    check("ovf_sticky", tx_overflow, 1'b1);

    // push into a full FIFO while the sink pops in the same cycle
    do_reset();
    for (int i = 1; i <= 16; i++) wr(32'h00030000, 8'(i));
    check("full_no_ovf", tx_overflow, 1'b0);
    io_tx_ready = 1'b1;
    wr(32'h00030000, 8'h55);
    io_tx_ready = 1'b0;
    check("pushpop_ovf", tx_overflow, 1'b0);
    rd(32'h00030004, 8'h01, "stat_still_full");
    io_tx_ready = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      check("pp_drain_data", io_tx_data, (i == 17) ? 8'h55 : 8'(i));
      idle();
    end
    io_tx_ready = 1'b0;
    check("pp_drain_empty", io_tx_valid, 1'b0);

    // simulation-end flag
    check("sim_end_pre", sim_end, 1'b0);
    wr(32'h00030004, 8'h00);
    check("sim_end_set", sim_end, 1'b1);
    wr(32'h00000020, 8'h11);
    rd(32'h00000020, 8'h11, "ram_after_end");
    check("sim_end_sticky", sim_end, 1'b1);

`ifdef RAM_IO_RX_EN
    io_rx_data  = 8'h3C;
    io_rx_valid = 1'b1;
    idle();
    io_rx_valid = 1'b0;
    check("rx_loaded", io_rx_ready, 1'b0);
    rd(32'h00030004, 8'h02, "stat_rx_full");
    rd(32'h00030000, 8'h3C, "rx_rd0");
    rd(32'h00030000, 8'h3C, "rx_rd1");
    rd(32'h00030000, 8'h3C, "rx_rd2");
    rd(32'h00030004, 8'h00, "stat_after_pop");
    check("rx_single_pop", io_rx_ready, 1'b1);
    // pop on an empty holding register while a new byte lands
    io_rx_data  = 8'h77;
    io_rx_valid = 1'b1;
    rd(32'h00030000, 8'h00, "rx_rd_empty");
    io_rx_valid = 1'b0;
    check("rx_kept_new", io_rx_ready, 1'b0);
    idle();
    rd(32'h00030000, 8'h77, "rx_rd_new");
    idle();
    check("rx_empty_again", io_rx_ready, 1'b1);
`else
    check("rx_off_ready", io_rx_ready, 1'b0);
    io_rx_data  = 8'h3C;
    io_rx_valid = 1'b1;
    rd(32'h00030000, 8'h00, "rx_off_rd");
    io_rx_valid = 1'b0;
    rd(32'h00030004, 8'h00, "rx_off_stat");
    check("rx_off_ready2", io_rx_ready, 1'b0);
`endif

    idle();
    idle();
    check("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
